// File: rtl/kp_entry_pkg.sv
// Shared key codes, sign-key class codes and entry FSM states for the keypad
// operand entry block.
package kp_entry_pkg;

    localparam int         MAX_DIGITS_DEF = 3;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_OP        = 4'hA;
    localparam logic [3:0] KEY_EQ        = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;

    localparam logic [2:0] SIGN_DIGIT = 3'b000;
    localparam logic [2:0] SIGN_OP    = 3'b001;
    localparam logic [2:0] SIGN_EQ    = 3'b100;
    localparam logic [2:0] SIGN_CLR   = 3'b011;

    typedef enum logic [1:0] {
        S_OPA  = 2'd0,
        S_OPB  = 2'd1,
        S_DONE = 2'd2
    } entry_state_t;

endpackage

// File: rtl/op_digit_accum.sv
// Combinational decimal digit accumulator: value*10 + digit with an 8-bit
// range check and a per-operand digit-count limit.
module op_digit_accum #(
    parameter int MAX_DIGITS = 3,
    parameter int CNT_W      = 2
) (
    input  logic [7:0]       value,
    input  logic [CNT_W-1:0] cnt,
    input  logic [3:0]       digit,
    output logic [7:0]       next_value,
    output logic [CNT_W-1:0] next_cnt,
    output logic             reject
);

    logic [11:0] prod;

    always_comb begin
        // 12 bits hold the worst case 255*10 + 15 without wrapping.
        prod       = ({4'd0, value} * 12'd10) + {8'd0, digit};
        reject     = (cnt >= CNT_W'(MAX_DIGITS)) || (prod > 12'd255);
        next_value = reject ? value : prod[7:0];
        next_cnt   = reject ? cnt : (cnt + CNT_W'(1));
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: turns debounced key strobes into operands A/B, a
// sign-key class code and a one-shot multiplier start when '=' closes an entry.
module keypad_operand_entry
    import kp_entry_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    // key_valid is a one-cycle strobe with no back-pressure: every strobe is
    // consumed in the cycle it is seen, and results appear one cycle later.
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         key_pressed,
    output logic [2:0]   is_sign_key,
    output logic [7:0]   temp_value_opA,
    output logic [7:0]   temp_value_opB,
    output logic         mult_start,
    output logic         entry_ovf,
    output entry_state_t dbg_state
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    entry_state_t     state_q, state_d;
    logic [7:0]       opa_q, opa_d;
    logic [7:0]       opb_q, opb_d;
    logic [CNT_W-1:0] cnta_q, cnta_d;
    logic [CNT_W-1:0] cntb_q, cntb_d;
    logic [2:0]       sign_q, sign_d;
    logic             key_pressed_q, key_pressed_d;
    logic             mult_start_q, mult_start_d;
    logic             entry_ovf_q, entry_ovf_d;

    logic [7:0]       acc_a_val, acc_b_val;
    logic [CNT_W-1:0] acc_a_cnt, acc_b_cnt;
    logic             rej_a, rej_b;

    op_digit_accum #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_accum_a (
        .value      (opa_q),
        .cnt        (cnta_q),
        .digit      (key_code),
        .next_value (acc_a_val),
        .next_cnt   (acc_a_cnt),
        .reject     (rej_a)
    );

    op_digit_accum #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_accum_b (
        .value      (opb_q),
        .cnt        (cntb_q),
        .digit      (key_code),
        .next_value (acc_b_val),
        .next_cnt   (acc_b_cnt),
        .reject     (rej_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_OPA;
            opa_q         <= '0;
            opb_q         <= '0;
            cnta_q        <= '0;
            cntb_q        <= '0;
            sign_q        <= SIGN_DIGIT;
            key_pressed_q <= 1'b0;
            mult_start_q  <= 1'b0;
            entry_ovf_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            cnta_q        <= cnta_d;
            cntb_q        <= cntb_d;
            sign_q        <= sign_d;
            key_pressed_q <= key_pressed_d;
            mult_start_q  <= mult_start_d;
            entry_ovf_q   <= entry_ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cnta_d        = cnta_q;
        cntb_d        = cntb_q;
        sign_d        = sign_q;
        key_pressed_d = 1'b0;
        mult_start_d  = 1'b0;
        entry_ovf_d   = 1'b0;

        if (key_valid) begin
            if (key_code <= KEY_DIGIT_MAX) begin
                case (state_q)
                    S_OPA: begin
                        if (rej_a) begin
                            entry_ovf_d = 1'b1;
                        end else begin
                            opa_d         = acc_a_val;
                            cnta_d        = acc_a_cnt;
                            key_pressed_d = 1'b1;
                            sign_d        = SIGN_DIGIT;
                        end
                    end
                    S_OPB: begin
                        if (rej_b) begin
                            entry_ovf_d = 1'b1;
                        end else begin
                            opb_d         = acc_b_val;
                            cntb_d        = acc_b_cnt;
                            key_pressed_d = 1'b1;
                            sign_d        = SIGN_DIGIT;
                        end
                    end
                    S_DONE: begin
                        // A digit after a finished entry starts a fresh one.
                        opa_d         = {4'd0, key_code};
                        opb_d         = '0;
                        cnta_d        = CNT_W'(1);
                        cntb_d        = '0;
                        state_d       = S_OPA;
                        key_pressed_d = 1'b1;
                        sign_d        = SIGN_DIGIT;
                    end
                    default: state_d = S_OPA;
                endcase
            end else if (key_code == KEY_OP) begin
                if (state_q == S_OPA && cnta_q != '0) begin
                    state_d       = S_OPB;
                    key_pressed_d = 1'b1;
                    sign_d        = SIGN_OP;
                end
            end else if (key_code == KEY_EQ) begin
                if (state_q == S_OPB && cntb_q != '0) begin
                    state_d       = S_DONE;
                    key_pressed_d = 1'b1;
                    mult_start_d  = 1'b1;
                    sign_d        = SIGN_EQ;
                end
            end else if (key_code == KEY_CLR) begin
                state_d       = S_OPA;
                opa_d         = '0;
                opb_d         = '0;
                cnta_d        = '0;
                cntb_d        = '0;
                key_pressed_d = 1'b1;
                sign_d        = SIGN_CLR;
            end
        end
    end

    assign key_pressed    = key_pressed_q;
    assign is_sign_key    = sign_q;
    assign temp_value_opA = opa_q;
    assign temp_value_opB = opb_q;
    assign mult_start     = mult_start_q;
    assign entry_ovf      = entry_ovf_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: directed scenarios plus random key streams,
// every cycle compared against a plain arithmetic model of the entry rules.
module tb_keypad_operand_entry;
    import kp_entry_pkg::*;

    localparam int MAXD = 3;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_pressed;
    logic [2:0]   is_sign_key;
    logic [7:0]   temp_value_opA;
    logic [7:0]   temp_value_opB;
    logic         mult_start;
    logic         entry_ovf;
    entry_state_t dbg_state;

    int cmp_count  = 0;
    int fail_count = 0;

    // Expected observation: {kp, sign, A, B, mult_start, ovf, state}
    logic [23:0] exp_q[$];

    // Reference model: operands as integers, entry phase 0=A, 1=B, 2=complete.
    int         m_a, m_b, m_ca, m_cb, m_phase;
    logic [2:0] m_sign;
    logic       m_kp, m_ms, m_ovf;

    keypad_operand_entry #(.MAX_DIGITS(MAXD)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_pressed    (key_pressed),
        .is_sign_key    (is_sign_key),
        .temp_value_opA (temp_value_opA),
        .temp_value_opB (temp_value_opB),
        .mult_start     (mult_start),
        .entry_ovf      (entry_ovf),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] obs_vec();
        return {key_pressed, is_sign_key, temp_value_opA, temp_value_opB,
                mult_start, entry_ovf, dbg_state};
    endfunction

    task automatic model_push();
        entry_state_t st;
        st = (m_phase == 0) ? S_OPA : (m_phase == 1) ? S_OPB : S_DONE;
        exp_q.push_back({m_kp, m_sign, 8'(m_a), 8'(m_b), m_ms, m_ovf, st});
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_phase = 0;
        m_sign = 3'b000; m_kp = 0; m_ms = 0; m_ovf = 0;
        model_push();
    endtask

    task automatic model_key(input logic v, input logic [3:0] code);
        int d;
        m_kp = 0; m_ms = 0; m_ovf = 0;
        d = int'(code);
        if (v) begin
            if (d <= 9) begin
                if (m_phase == 2) begin
                    m_a = d; m_b = 0; m_ca = 1; m_cb = 0; m_phase = 0;
                    m_kp = 1; m_sign = 3'b000;
                end else if (m_phase == 0) begin
                    if (m_ca == MAXD || m_a * 10 + d > 255) m_ovf = 1;
                    else begin
                        m_a = m_a * 10 + d; m_ca++; m_kp = 1; m_sign = 3'b000;
                    end
                end else begin
                    if (m_cb == MAXD || m_b * 10 + d > 255) m_ovf = 1;
                    else begin
                        m_b = m_b * 10 + d; m_cb++; m_kp = 1; m_sign = 3'b000;
                    end
                end
            end else if (d == 10) begin
                if (m_phase == 0 && m_ca > 0) begin
                    m_phase = 1; m_kp = 1; m_sign = 3'b001;
                end
            end else if (d == 11) begin
                if (m_phase == 1 && m_cb > 0) begin
                    m_phase = 2; m_kp = 1; m_ms = 1; m_sign = 3'b100;
                end
            end else if (d == 12) begin
                m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_phase = 0;
                m_kp = 1; m_sign = 3'b011;
            end
        end
        model_push();
    endtask

    // Driver: present one cycle of input, sample 1 time unit after the edge.
    task automatic drive_key(input logic v, input logic [3:0] code);
        @(negedge clk);
        rst       = 1'b0;
        key_valid = v;
        key_code  = code;
        @(posedge clk);
        #1;
        model_key(v, code);
    endtask

    task automatic drive_rst(input logic v, input logic [3:0] code);
        @(negedge clk);
        rst       = 1'b1;
        key_valid = v;
        key_code  = code;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [23:0] e;
        drive_rst(1'b0, 4'h0);
        e = exp_q.pop_front();
        cmp_count++;
        if (obs_vec() !== e) begin
            fail_count++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_basic();
        logic [3:0]  keys[$];
        logic [23:0] e;
        keys = '{4'h1, 4'h2, 4'hA, 4'h3, 4'hB};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL basic k%0d: got %h expected %h", i, obs_vec(), e);
            end
        end
        cmp_count++;
        if (temp_value_opA !== 8'd12 || temp_value_opB !== 8'd3 || mult_start !== 1'b1) begin
            fail_count++;
            $display("FAIL basic_result: A=%0d B=%0d ms=%b expected A=12 B=3 ms=1",
                     temp_value_opA, temp_value_opB, mult_start);
        end
    endtask

    task automatic test_digit_limit();
        logic [3:0]  keys[$];
        logic [23:0] e;
        keys = '{4'hC, 4'h2, 4'h5, 4'h6, 4'hC, 4'h2, 4'h5, 4'h5, 4'h0,
                 4'hC, 4'h0, 4'h0, 4'h7, 4'h1};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL digit_limit k%0d: got %h expected %h", i, obs_vec(), e);
            end
            if (i == 3) begin
                cmp_count++;
                if (temp_value_opA !== 8'd25 || entry_ovf !== 1'b1) begin
                    fail_count++;
                    $display("FAIL ovf_range: A=%0d ovf=%b expected A=25 ovf=1",
                             temp_value_opA, entry_ovf);
                end
            end
            if (i == 8) begin
                cmp_count++;
                if (temp_value_opA !== 8'd255 || entry_ovf !== 1'b1 || key_pressed !== 1'b0) begin
                    fail_count++;
                    $display("FAIL ovf_255: A=%0d ovf=%b kp=%b expected A=255 ovf=1 kp=0",
                             temp_value_opA, entry_ovf, key_pressed);
                end
            end
        end
    endtask

    task automatic test_ignored_keys();
        logic [3:0]  keys[$];
        logic [23:0] e;
        keys = '{4'hC, 4'hA, 4'hB, 4'h4, 4'hA, 4'hA, 4'hB};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL ignored k%0d: got %h expected %h", i, obs_vec(), e);
            end
        end
        cmp_count++;
        if (key_pressed !== 1'b0 || dbg_state !== S_OPB || mult_start !== 1'b0) begin
            fail_count++;
            $display("FAIL eq_without_b: kp=%b state=%0d ms=%b expected kp=0 state=1 ms=0",
                     key_pressed, dbg_state, mult_start);
        end
        keys = '{4'h1, 4'hB, 4'hA, 4'hB, 4'hB};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL done_hold k%0d: got %h expected %h", i, obs_vec(), e);
            end
        end
    endtask

    task automatic test_restart();
        logic [23:0] e;
        drive_key(1'b1, 4'h7);
        e = exp_q.pop_front();
        cmp_count++;
        if (obs_vec() !== e || temp_value_opA !== 8'd7 || temp_value_opB !== 8'd0
            || dbg_state !== S_OPA) begin
            fail_count++;
            $display("FAIL restart: got %h expected %h (A=7 B=0 state=0)", obs_vec(), e);
        end
    endtask

    task automatic test_clear_in_opb();
        logic [3:0]  keys[$];
        logic [23:0] e;
        keys = '{4'hA, 4'h2, 4'hC};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL clear k%0d: got %h expected %h", i, obs_vec(), e);
            end
        end
        cmp_count++;
        if (temp_value_opA !== 8'd0 || temp_value_opB !== 8'd0 || is_sign_key !== 3'b011
            || dbg_state !== S_OPA) begin
            fail_count++;
            $display("FAIL clear_result: A=%0d B=%0d sign=%b state=%0d expected 0 0 011 0",
                     temp_value_opA, temp_value_opB, is_sign_key, dbg_state);
        end
    endtask

    task automatic test_unused_codes();
        logic [3:0]  keys[$];
        logic [23:0] e;
        keys = '{4'hD, 4'h1, 4'hE, 4'hA, 4'hF, 4'h2, 4'hD, 4'hB, 4'hD, 4'hE, 4'hF};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL unused k%0d code %h: got %h expected %h", i, keys[i], obs_vec(), e);
            end
        end
    endtask

    task automatic test_reset_with_key();
        logic [23:0] e;
        drive_key(1'b1, 4'h4);
        void'(exp_q.pop_front());
        drive_rst(1'b1, 4'h5);
        e = exp_q.pop_front();
        cmp_count++;
        if (obs_vec() !== e) begin
            fail_count++;
            $display("FAIL reset_with_key: got %h expected %h", obs_vec(), e);
        end
        drive_key(1'b0, 4'h0);
        e = exp_q.pop_front();
        cmp_count++;
        if (obs_vec() !== e) begin
            fail_count++;
            $display("FAIL reset_after: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  keys[$];
        logic [23:0] e;
        keys = '{4'hC, 4'h1, 4'h2};
        foreach (keys[i]) begin
            drive_key(1'b1, keys[i]);
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e || key_pressed !== 1'b1) begin
                fail_count++;
                $display("FAIL back_to_back k%0d: got %h expected %h", i, obs_vec(), e);
            end
        end
        cmp_count++;
        if (temp_value_opA !== 8'd12) begin
            fail_count++;
            $display("FAIL back_to_back_A: got %0d expected 12", temp_value_opA);
        end
        drive_key(1'b0, 4'h0);
        e = exp_q.pop_front();
        cmp_count++;
        if (obs_vec() !== e) begin
            fail_count++;
            $display("FAIL back_to_back_idle: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_random();
        logic [23:0] e;
        logic        v;
        logic [3:0]  c;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                drive_rst(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end else begin
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 9))
                                                 : 4'($urandom_range(10, 15));
                drive_key(v, c);
            end
            e = exp_q.pop_front();
            cmp_count++;
            if (obs_vec() !== e) begin
                fail_count++;
                $display("FAIL random n%0d: got %h expected %h", n, obs_vec(), e);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        test_reset();
        test_basic();
        test_digit_limit();
        test_ignored_keys();
        test_restart();
        test_clear_in_opb();
        test_unused_codes();
        test_reset_with_key();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
